fpga_input_conditioner: RTL and testbench
=========================================

Name: fpga_input_conditioner

Overview:
Input-side companion to the switch/button-to-LED datapath. It conditions the raw board inputs (16 slide switches, 4 push buttons) before they reach the LED logic: a 2-FF synchronizer, a per-input debounce filter, button rising-edge pulses, and an optional toggle latch. In toggle mode each button press flips its LED group's off-state instead of requiring a held button. Outputs drive the sw/btn inputs of the LED block directly.

Parameters:
NUM_SW, 16, number of switch inputs
NUM_BTN, 4, number of button inputs (one per 4-LED group)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clocks required before a clean output changes (10 ms at 100 MHz); legal range >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
sw_raw  input  NUM_SW  asynchronous switch inputs
btn_raw  input  NUM_BTN  asynchronous button inputs
mode_toggle  input  1  0 = momentary (btn_mask follows btn_clean), 1 = toggle latch; treated as quasi-static, not synchronized
sw_clean  output  NUM_SW  debounced switch levels
btn_clean  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse per debounced button 0->1 transition
btn_mask  output  NUM_BTN  group-off mask for the LED block

Behaviour:
- Reset (rst=1 at a rising edge): sync flops, debounce counters, sw_clean, btn_clean, btn_press, and the toggle register all go to 0. btn_mask reads 0. Reset mid-debounce discards the partial count.
- Synchronizer: raw -> s1 -> s2, one flop each. Only s2 feeds the filter.
- Debounce, per input, independent: counter cnt of width $clog2(DEBOUNCE_CYCLES).
  - On an edge with s2 == clean: cnt <= 0.
  - On an edge with s2 != clean and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - On an edge with s2 != clean and cnt == DEBOUNCE_CYCLES-1: clean <= s2, cnt <= 0.
  - Latency: a clean raw step is reflected on clean at the (DEBOUNCE_CYCLES+2)th rising edge. Edge 1 is the first edge that samples the new raw value.
  - A glitch whose s2 mismatch lasts fewer than DEBOUNCE_CYCLES edges produces no output change, and cnt returns to 0.
- btn_press[i]: registered. It is high for exactly the one cycle following the edge where btn_clean[i] goes 0->1. There is no pulse on 1->0. Holding the button produces no further pulses.
- Toggle register tgl[i]: flips on each edge where btn_press[i]=1. It is not affected by mode_toggle, so switching mode does not lose state.
- btn_mask = mode_toggle ? tgl : btn_clean (combinational mux of registered values).
- Simultaneous presses on several buttons each produce their own pulse in the same cycle.
- Inputs already high at reset release are debounced normally. btn_clean rises after DEBOUNCE_CYCLES+2 edges and generates a btn_press pulse, which is intentional.
- No other state machines. All outputs are glitch-free registered values except the btn_mask mux.

Decomposition:
- Package fpga_io_pkg: NUM_SW=16, NUM_BTN=4, GROUP_W=4, DEBOUNCE_CYCLES_DEFAULT, and a function returning the counter width.
- Sub-module debounce_cell (param DEBOUNCE_CYCLES; ports clk, rst, din_raw, dout_clean, rise_pulse) contains the 2-FF sync, the counter and the edge pulse.
- The top level instantiates NUM_SW + NUM_BTN cells via generate and adds the toggle register and mask mux.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and a 10 ns clock.
1. Reset with sw_raw=16'hFFFF held -> outputs 0 during reset; sw_clean=16'hFFFF exactly at the 6th edge after rst deasserts (edge 1 = first sampling edge), not at the 5th.
2. btn_raw[0] 0->1 held -> btn_clean[0]=1 after 6 edges; btn_press[0]=1 for exactly one cycle; no further pulse while held.
3. Bounce on btn_raw[2]: high 2 cycles, low 1, high 1, then low -> btn_clean[2] stays 0, btn_press stays 0.
4. mode_toggle=1, two separated presses on btn[1] -> btn_mask=4'b0010 after the first, 4'b0000 after the second; flips occur one cycle after each press pulse.
5. mode_toggle=0, hold btn_raw=4'b1101 -> btn_mask=4'b1101 after debounce; release -> 4'b0000 after 6 edges. Then set mode_toggle=1 -> btn_mask shows the tgl contents (4'b1101).
6. Assert rst for 1 cycle mid-debounce (sw_raw 16'h0000->16'hA5A5, rst at edge 3) -> all outputs 0; sw_clean=16'hA5A5 only 6 edges after rst release.

Source files
------------

// File: rtl/fpga_io_pkg.sv
// rtl/fpga_io_pkg.sv - shared constants and helpers for the board input conditioner
//
// Purpose: board-level input counts and the debounce counter width helper used by
//          debounce_cell and fpga_input_conditioner.
package fpga_io_pkg;

   localparam int NUM_SW                  = 16;
   localparam int NUM_BTN                 = 4;
   localparam int GROUP_W                 = 4;          // LEDs per button group
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;  // 10 ms at 100 MHz

   // Counter must hold values 0 .. n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - 2-FF synchronizer, stability counter and rising-edge pulse for one input
//
// Purpose: conditions one asynchronous input into a clean level plus a one-cycle
//          pulse on each clean 0->1 transition.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   din_raw    in   asynchronous raw input
//   dout_clean out  debounced level (registered)
//   rise_pulse out  one-cycle pulse following a clean 0->1 change (registered)
module debounce_cell
   import fpga_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic din_raw,
   output logic dout_clean,
   output logic rise_pulse
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          clean_q, clean_d;
   logic          rise_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any edge where the synchronized input agrees with the clean level restarts
   // the count, so a glitch shorter than DEBOUNCE_CYCLES leaves no trace.
   always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (s2_q != clean_q) begin
         if (cnt_q == CNT_MAX) begin
            clean_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         s1_q    <= din_raw;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         // Pulse is registered alongside the clean level it reports.
         rise_q  <= clean_d & ~clean_q;
      end
   end

   assign dout_clean = clean_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/fpga_input_conditioner.sv
// rtl/fpga_input_conditioner.sv - debounced switches/buttons with press pulses and toggle mask
//
// Purpose: conditions raw slide switches and push buttons for the LED block and
//          produces the per-group off mask (momentary or toggle-latched).
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   sw_raw      in   asynchronous switch inputs [NUM_SW]
//   btn_raw     in   asynchronous button inputs [NUM_BTN]
//   mode_toggle in   0 = mask follows btn_clean, 1 = mask from toggle register (quasi-static)
//   sw_clean    out  debounced switch levels
//   btn_clean   out  debounced button levels
//   btn_press   out  one-cycle pulse per debounced button press
//   btn_mask    out  group-off mask for the LED block
module fpga_input_conditioner #(
   parameter int NUM_SW          = fpga_io_pkg::NUM_SW,
   parameter int NUM_BTN         = fpga_io_pkg::NUM_BTN,
   parameter int DEBOUNCE_CYCLES = fpga_io_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SW-1:0]  sw_raw,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               mode_toggle,
   output logic [NUM_SW-1:0]  sw_clean,
   output logic [NUM_BTN-1:0] btn_clean,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_mask
);

   logic [NUM_SW-1:0]  sw_rise_unused;
   logic [NUM_BTN-1:0] tgl_q, tgl_d;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk        (clk),
         .rst        (rst),
         .din_raw    (sw_raw[i]),
         .dout_clean (sw_clean[i]),
         .rise_pulse (sw_rise_unused[i])
      );
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk        (clk),
         .rst        (rst),
         .din_raw    (btn_raw[i]),
         .dout_clean (btn_clean[i]),
         .rise_pulse (btn_press[i])
      );
   end

   // Toggle state advances regardless of mode so switching modes keeps it.
   assign tgl_d = tgl_q ^ btn_press;

   always_ff @(posedge clk) begin
      if (rst) begin
         tgl_q <= '0;
      end else begin
         tgl_q <= tgl_d;
      end
   end

   assign btn_mask = mode_toggle ? tgl_q : btn_clean;

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// tb/tb_fpga_input_conditioner.sv - self-checking bench for fpga_input_conditioner
module tb_fpga_input_conditioner;

   typedef struct {
      logic        rst;
      logic [15:0] sw;
      logic [3:0]  btn;
      logic        mode;
      logic [15:0] esw;
      logic [3:0]  ebc;
      logic [3:0]  ebp;
      logic [3:0]  emask;
      string       tag;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] sw_raw = '0;
   logic [3:0]  btn_raw = '0;
   logic        mode_toggle = 1'b0;
   logic [15:0] sw_clean;
   logic [3:0]  btn_clean, btn_press, btn_mask;

   int total = 0;
   int bad   = 0;

   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   fpga_input_conditioner #(
      .NUM_SW          (16),
      .NUM_BTN         (4),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_raw      (sw_raw),
      .btn_raw     (btn_raw),
      .mode_toggle (mode_toggle),
      .sw_clean    (sw_clean),
      .btn_clean   (btn_clean),
      .btn_press   (btn_press),
      .btn_mask    (btn_mask)
   );

   function automatic void add(input int n, input string tag, input logic r,
                               input logic [15:0] s, input logic [3:0] b, input logic m,
                               input logic [15:0] esw, input logic [3:0] ebc,
                               input logic [3:0] ebp, input logic [3:0] emask);
      vec_t v;
      v.rst = r; v.sw = s; v.btn = b; v.mode = m;
      v.esw = esw; v.ebc = ebc; v.ebp = ebp; v.emask = emask; v.tag = tag;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s row %0d: got %h want %h", name, idx, act, want);
      end
   endtask

   // Drive one edge's worth of inputs and queue the outputs expected after it.
   task automatic apply(input vec_t v);
      @(negedge clk);
      rst         = v.rst;
      sw_raw      = v.sw;
      btn_raw     = v.btn;
      mode_toggle = v.mode;
      exp_q.push_back(v);
   endtask

   int row = 0;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         vec_t e;
         e = exp_q.pop_front();
         chk({e.tag, ".sw_clean"},  row, sw_clean,          e.esw);
         chk({e.tag, ".btn_clean"}, row, {12'h0, btn_clean}, {12'h0, e.ebc});
         chk({e.tag, ".btn_press"}, row, {12'h0, btn_press}, {12'h0, e.ebp});
         chk({e.tag, ".btn_mask"},  row, {12'h0, btn_mask},  {12'h0, e.emask});
         row++;
      end
   end

   initial begin
      // 1: inputs high through reset, clean after the 6th edge only
      add(2, "rst_hold", 1, 16'hFFFF, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(5, "rst_rel",  0, 16'hFFFF, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(2, "rst_rel",  0, 16'hFFFF, 4'h0, 0, 16'hFFFF, 4'h0, 4'h0, 4'h0);
      // 2: single press on btn0, one pulse, then release
      add(5, "press0",   0, 16'hFFFF, 4'h1, 0, 16'hFFFF, 4'h0, 4'h0, 4'h0);
      add(1, "press0",   0, 16'hFFFF, 4'h1, 0, 16'hFFFF, 4'h1, 4'h1, 4'h1);
      add(4, "hold0",    0, 16'hFFFF, 4'h1, 0, 16'hFFFF, 4'h1, 4'h0, 4'h1);
      add(5, "rel0",     0, 16'hFFFF, 4'h0, 0, 16'hFFFF, 4'h1, 4'h0, 4'h1);
      add(1, "rel0",     0, 16'hFFFF, 4'h0, 0, 16'hFFFF, 4'h0, 4'h0, 4'h0);
      add(1, "tgl0",     0, 16'hFFFF, 4'h0, 1, 16'hFFFF, 4'h0, 4'h0, 4'h1);
      add(2, "rst",      1, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      // 3: bounce on btn2 never settles long enough
      add(2, "bounce",   0, 16'h0000, 4'h4, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(1, "bounce",   0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(1, "bounce",   0, 16'h0000, 4'h4, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(8, "bounce",   0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      // 4: toggle mode, two presses on btn1
      add(5, "tglA",     0, 16'h0000, 4'h2, 1, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(1, "tglA",     0, 16'h0000, 4'h2, 1, 16'h0000, 4'h2, 4'h2, 4'h0);
      add(2, "tglA",     0, 16'h0000, 4'h2, 1, 16'h0000, 4'h2, 4'h0, 4'h2);
      add(5, "tglArel",  0, 16'h0000, 4'h0, 1, 16'h0000, 4'h2, 4'h0, 4'h2);
      add(1, "tglArel",  0, 16'h0000, 4'h0, 1, 16'h0000, 4'h0, 4'h0, 4'h2);
      add(5, "tglB",     0, 16'h0000, 4'h2, 1, 16'h0000, 4'h0, 4'h0, 4'h2);
      add(1, "tglB",     0, 16'h0000, 4'h2, 1, 16'h0000, 4'h2, 4'h2, 4'h2);
      add(2, "tglB",     0, 16'h0000, 4'h2, 1, 16'h0000, 4'h2, 4'h0, 4'h0);
      add(5, "tglBrel",  0, 16'h0000, 4'h0, 1, 16'h0000, 4'h2, 4'h0, 4'h0);
      add(1, "tglBrel",  0, 16'h0000, 4'h0, 1, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(2, "rst",      1, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      // 5: momentary mask, multi-button press, then view toggle state
      add(5, "mom",      0, 16'h0000, 4'hD, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(1, "mom",      0, 16'h0000, 4'hD, 0, 16'h0000, 4'hD, 4'hD, 4'hD);
      add(2, "mom",      0, 16'h0000, 4'hD, 0, 16'h0000, 4'hD, 4'h0, 4'hD);
      add(5, "momrel",   0, 16'h0000, 4'h0, 0, 16'h0000, 4'hD, 4'h0, 4'hD);
      add(1, "momrel",   0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(2, "modesw",   0, 16'h0000, 4'h0, 1, 16'h0000, 4'h0, 4'h0, 4'hD);
      add(1, "mode0",    0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);

      foreach (vecs[i]) apply(vecs[i]);

      // 6: reset in the middle of a debounce discards the partial count
      vecs.delete();
      add(2, "midrst",   0, 16'hA5A5, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(1, "midrst",   1, 16'hA5A5, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(5, "midrel",   0, 16'hA5A5, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 4'h0);
      add(1, "midrel",   0, 16'hA5A5, 4'h0, 0, 16'hA5A5, 4'h0, 4'h0, 4'h0);
      add(1, "midtgl",   0, 16'hA5A5, 4'h0, 1, 16'hA5A5, 4'h0, 4'h0, 4'h0);
      apply(vecs[0]);
      apply(vecs[1]);
      apply(vecs[2]);
      for (int i = 3; i < vecs.size(); i++) apply(vecs[i]);

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
